// File: rtl/elastic_stage_reg.sv
// -----------------------------------------------------------------------------
// elastic_stage_reg
//
// Parametrised pipeline stage register for the 5-stage core. One instance sits
// on each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an
// arbitrary payload with a valid/ready handshake, using a 2-entry skid buffer
// so that one cycle of downstream backpressure costs no upstream throughput.
// It also supports a hazard hold, a flush and a saturating stall counter for
// performance monitoring.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge when valid and ready are both 1.
//   valid must not depend on ready on the same side. Upstream:
//     acc = in_valid & in_ready. Downstream: dep = out_valid & out_ready & ~hold.
//   hold masks out_ready, so a held payload stays on out_data unconsumed.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset; clears everything at once
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload this cycle (state != FULL)
//   in_data    upstream payload
//   out_valid  payload available downstream (state != EMPTY)
//   out_ready  downstream accepts
//   out_data   head payload (main register), BUBBLE_VAL when empty
//   hold       hazard stall; blocks the downstream transfer
//   flush      synchronous discard of all held payloads
//   clr_stats  synchronous clear of stall_cnt
//   occupancy  entries held (0..2); this is the raw FSM state encoding
//   stall_cnt  saturating count of cycles with out_valid=1 and no dep
// -----------------------------------------------------------------------------
module elastic_stage_reg #(
  parameter int                   PAYLOAD_W  = 64,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = {PAYLOAD_W{1'b0}},
  parameter int                   CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 clr_stats,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  // State encoding equals the number of held entries, so occupancy is the
  // state register itself and doubles as the FSM debug view.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               state;
  logic [PAYLOAD_W-1:0] main_q;   // head entry, drives out_data
  logic [PAYLOAD_W-1:0] skid_q;   // overflow entry, always behind main_q
  logic [CNT_W-1:0]     cnt_q;

  logic acc;
  logic dep;

  // Outputs are decoded from state only: there is no combinational path from
  // in_* to out_*, nor from out_ready to in_ready.
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    out_data  = out_valid ? main_q : BUBBLE_VAL;
    occupancy = state;
    stall_cnt = cnt_q;
  end

  always_comb begin
    acc = in_valid & in_ready;
    dep = out_valid & out_ready & ~hold;
  end

  // Storage FSM. Flush wins over every transition: a dep in that cycle has
  // already been seen downstream, and an acc is taken upstream but dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (acc && dep) begin
            // Pass-through at full rate: head leaves, new payload replaces it.
            main_q <= in_data;
          end else if (acc) begin
            // Downstream stalled: park the new payload behind the head.
            skid_q <= in_data;
            state  <= FULL;
          end else if (dep) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is 0 here, so only a departure can happen.
          if (dep) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= BUBBLE_VAL;
          skid_q <= BUBBLE_VAL;
        end
      endcase
    end
  end

  // Stall counter: counts cycles where a payload is offered but not taken,
  // including hold stalls. Clear wins over increment; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_stats) begin
      cnt_q <= '0;
    end else if (out_valid && !dep && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_elastic_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_stage_reg
//
// Directed bench for elastic_stage_reg. A default-width instance covers the
// datapath, backpressure, hold, flush and async reset; a narrow instance with
// a 3-bit stall counter covers saturation and clear.
// -----------------------------------------------------------------------------
module tb_elastic_stage_reg;

  localparam int W = 64;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance
  logic         in_valid, in_ready, out_valid, out_ready;
  logic         hold, flush, clr_stats;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cnt;

  // narrow-counter instance
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic       s_hold, s_flush, s_clr_stats;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_occupancy;
  logic [2:0] s_stall_cnt;

  int checks = 0;
  int errors = 0;

  elastic_stage_reg dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hold(hold), .flush(flush), .clr_stats(clr_stats),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  elastic_stage_reg #(.PAYLOAD_W(8), .BUBBLE_VAL(8'h00), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .hold(s_hold), .flush(s_flush), .clr_stats(s_clr_stats),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  // driver: advance one clock, sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_data = '0; out_ready = 0; hold = 0; flush = 0; clr_stats = 0;
    s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_hold = 0; s_flush = 0; s_clr_stats = 0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_stall",     64'(stall_cnt), 64'd0);
    reset = 1'b0;

    // streaming at 1 payload/cycle
    in_valid = 1; out_ready = 1; in_data = 64'h11;
    tick();
    chk("stream_11", out_data, 64'h11);
    chk("stream_occ1", 64'(occupancy), 64'd1);
    in_data = 64'h22;
    tick();
    chk("stream_22", out_data, 64'h22);
    in_data = 64'h33;
    tick();
    chk("stream_33", out_data, 64'h33);
    chk("stream_occ3", 64'(occupancy), 64'd1);
    in_valid = 0;
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // backpressure into the skid register
    out_ready = 0; in_valid = 1; in_data = 64'hA;
    tick();
    in_data = 64'hB;
    tick();
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_in_ready0", 64'(in_ready), 64'd0);
    chk("bp_head_A", out_data, 64'hA);
    in_valid = 0; out_ready = 1;
    tick();
    chk("bp_head_B", out_data, 64'hB);
    chk("bp_in_ready1", 64'(in_ready), 64'd1);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_stall", 64'(stall_cnt), 64'd1);
    clr_stats = 1;
    tick();
    clr_stats = 0;
    chk("clr_stall", 64'(stall_cnt), 64'd0);

    // hazard hold with out_ready asserted
    in_valid = 1; in_data = 64'h5;
    tick();
    in_valid = 0; hold = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_data", out_data, 64'h5);
      chk("hold_occ", 64'(occupancy), 64'd1);
    end
    chk("hold_stall5", 64'(stall_cnt), 64'd5);
    hold = 0;
    tick();
    chk("hold_release_empty", 64'(out_valid), 64'd0);
    chk("hold_release_stall", 64'(stall_cnt), 64'd5);

    // flush while FULL, with 0x77 offered in the same cycle
    out_ready = 0; in_valid = 1; in_data = 64'h1;
    tick();
    in_data = 64'h2;
    tick();
    chk("fl_full", 64'(occupancy), 64'd2);
    flush = 1; in_data = 64'h77;
    tick();
    flush = 0; in_valid = 0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_data", out_data, 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_stall_kept", 64'(stall_cnt), 64'd7);
    out_ready = 1;
    tick();
    chk("fl_no_77", out_data, 64'd0);
    chk("fl_still_empty", 64'(out_valid), 64'd0);

    // flush from ONE with acc and dep in the same cycle: new payload dropped
    in_valid = 1; in_data = 64'h3;
    tick();
    flush = 1; in_data = 64'h44;
    tick();
    flush = 0; in_valid = 0;
    chk("fl1_out_valid", 64'(out_valid), 64'd0);
    chk("fl1_out_data", out_data, 64'd0);
    chk("fl1_stall", 64'(stall_cnt), 64'd7);

    // narrow counter saturation
    s_in_valid = 1; s_in_data = 8'h5A;
    tick();
    s_in_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_stall7", 64'(s_stall_cnt), 64'd7);
    chk("sat_data", 64'(s_out_data), 64'h5A);
    s_clr_stats = 1;
    tick();
    s_clr_stats = 0;
    chk("sat_clr", 64'(s_stall_cnt), 64'd0);

    // asynchronous reset mid-cycle while FULL
    out_ready = 0; in_valid = 1; in_data = 64'hC1;
    tick();
    in_data = 64'hC2;
    tick();
    in_valid = 0;
    chk("ar_full", 64'(occupancy), 64'd2);
    #2;
    reset = 1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_out_data", out_data, 64'd0);
    chk("ar_stall", 64'(stall_cnt), 64'd0);
    reset = 0;
    tick();
    chk("ar_after", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
